// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the SoC wrapper: qualifies PLL lock and the board button,
// then releases peripheral reset ahead of core reset, re-entering reset on fault events.
module rst_seq_ctrl #(
    parameter int LOCK_STABLE = 64,
    parameter int HOLD_CYC    = 256,
    parameter int STAGE_GAP   = 16,
    parameter int DBNC_CYC    = 50000,
    parameter int CNT_W       = 16,
    parameter int DBNC_W      = 17
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       btn_rst_n_i,
    input  logic       sw_rst_req_i,
    output logic       periph_rst_n_o,
    output logic       core_rst_n_o,
    output logic [2:0] state_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] lock_loss_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REL_PERIPH = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    localparam logic [1:0]        CAUSE_LOCK = 2'd1;
    localparam logic [1:0]        CAUSE_BTN  = 2'd2;
    localparam logic [1:0]        CAUSE_SW   = 2'd3;
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [DBNC_W-1:0] DBNC_ZERO  = {DBNC_W{1'b0}};
    localparam logic [DBNC_W-1:0] DBNC_ONE   = DBNC_W'(1);
    localparam logic [DBNC_W-1:0] DBNC_LAST  = DBNC_W'(DBNC_CYC - 1);

    logic              lock_meta_q, lock_sync_q;
    logic              btn_meta_q, btn_sync_q;
    logic              btn_lvl_s;
    logic              btn_pressed_q, btn_pressed_d;
    logic [DBNC_W-1:0] dbnc_cnt_q, dbnc_cnt_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        loss_cnt_q, loss_cnt_d;
    logic              periph_q, periph_d;
    logic              core_q, core_d;

    // Two-flop synchronisers for the asynchronous lock and button inputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_sync_q <= lock_meta_q;
            btn_meta_q  <= btn_rst_n_i;
            btn_sync_q  <= btn_meta_q;
        end
    end

    assign btn_lvl_s = ~btn_sync_q;

    // Button debounce: accept a level change only after DBNC_CYC disagreeing cycles in a row
    always_comb begin
        btn_pressed_d = btn_pressed_q;
        dbnc_cnt_d    = DBNC_ZERO;
        if (btn_lvl_s != btn_pressed_q) begin
            if (dbnc_cnt_q == DBNC_LAST) begin
                btn_pressed_d = ~btn_pressed_q;
                dbnc_cnt_d    = DBNC_ZERO;
            end else begin
                btn_pressed_d = btn_pressed_q;
                dbnc_cnt_d    = dbnc_cnt_q + DBNC_ONE;
            end
        end else begin
            btn_pressed_d = btn_pressed_q;
            dbnc_cnt_d    = DBNC_ZERO;
        end
    end

    // Sequencer next-state, counter, cause and lock-loss bookkeeping
    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = CNT_ZERO;
        cause_d    = cause_q;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q == 1'b0) begin
                    seq_cnt_d = CNT_ZERO;
                end else if (seq_cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    seq_cnt_d = seq_cnt_q + CNT_ONE;
                end
            end
            ST_HOLD, ST_REL_PERIPH, ST_RUN: begin
                if (lock_sync_q == 1'b0) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end else begin
                        loss_cnt_d = loss_cnt_q;
                    end
                end else if (state_q == ST_HOLD) begin
                    // Count stays parked on its terminal value while the button is held
                    if (seq_cnt_q != HOLD_LAST) begin
                        seq_cnt_d = seq_cnt_q + CNT_ONE;
                    end else if (btn_pressed_q) begin
                        seq_cnt_d = seq_cnt_q;
                    end else begin
                        state_d = ST_REL_PERIPH;
                    end
                end else if (state_q == ST_REL_PERIPH) begin
                    if (seq_cnt_q == GAP_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        seq_cnt_d = seq_cnt_q + CNT_ONE;
                    end
                end else if (btn_pressed_q) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_BTN;
                end else if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SW;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        periph_d = (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
        core_d   = (state_d == ST_RUN);
    end

    // State, counters and reset outputs; outputs decoded from next state to stay aligned
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_pressed_q <= 1'b0;
            dbnc_cnt_q    <= DBNC_ZERO;
            state_q       <= ST_IDLE;
            seq_cnt_q     <= CNT_ZERO;
            cause_q       <= 2'd0;
            loss_cnt_q    <= 8'd0;
            periph_q      <= 1'b0;
            core_q        <= 1'b0;
        end else begin
            btn_pressed_q <= btn_pressed_d;
            dbnc_cnt_q    <= dbnc_cnt_d;
            state_q       <= state_d;
            seq_cnt_q     <= seq_cnt_d;
            cause_q       <= cause_d;
            loss_cnt_q    <= loss_cnt_d;
            periph_q      <= periph_d;
            core_q        <= core_d;
        end
    end

    assign periph_rst_n_o  = periph_q;
    assign core_rst_n_o    = core_q;
    assign state_o         = state_q;
    assign rst_cause_o     = cause_q;
    assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random lock/button/software stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_rst_seq_ctrl;

    localparam int LOCK_STABLE = 4;
    localparam int HOLD_CYC    = 8;
    localparam int STAGE_GAP   = 2;
    localparam int DBNC_CYC    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       btn_rst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       periph_rst_n, core_rst_n;
    logic [2:0] state;
    logic [1:0] rst_cause;
    logic [7:0] llc;

    int n_checks = 0;
    int n_fail   = 0;

    // model
    int m_state, m_run, m_in, m_cause, m_llc, m_dbrun;
    bit m_pressed;
    bit lh[$];
    bit bh[$];

    rst_seq_ctrl #(
        .LOCK_STABLE(LOCK_STABLE), .HOLD_CYC(HOLD_CYC), .STAGE_GAP(STAGE_GAP),
        .DBNC_CYC(DBNC_CYC), .CNT_W(16), .DBNC_W(17)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pll_locked_i(pll_locked), .btn_rst_n_i(btn_rst_n),
        .sw_rst_req_i(sw_rst_req), .periph_rst_n_o(periph_rst_n), .core_rst_n_o(core_rst_n),
        .state_o(state), .rst_cause_o(rst_cause), .lock_loss_cnt_o(llc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_in = 0; m_cause = 0; m_llc = 0; m_dbrun = 0;
        m_pressed = 1'b0;
        lh.delete();
        bh.delete();
    endtask

    // One clock edge of the sequencing rules, using the inputs present at that edge
    task automatic model_step();
        bit ls, bl;
        int ns;
        ls = (lh.size() >= 2) ? lh[lh.size()-2] : 1'b0;
        bl = (bh.size() >= 2) ? !bh[bh.size()-2] : 1'b1;
        ns = m_state;
        case (m_state)
            0: ns = 1;
            1: begin
                if (ls) begin
                    m_run++;
                    if (m_run >= LOCK_STABLE) ns = 2;
                end else m_run = 0;
            end
            2, 3, 4: begin
                if (!ls) begin
                    ns = 1; m_cause = 1;
                    if (m_llc < 255) m_llc++;
                end else if (m_state == 2) begin
                    m_in++;
                    if (m_in >= HOLD_CYC && !m_pressed) ns = 3;
                end else if (m_state == 3) begin
                    m_in++;
                    if (m_in == STAGE_GAP) ns = 4;
                end else if (m_pressed) begin
                    ns = 2; m_cause = 2;
                end else if (sw_rst_req) begin
                    ns = 2; m_cause = 3;
                end
            end
            default: ns = 0;
        endcase
        if (ns != m_state) begin
            m_run = 0; m_in = 0;
        end
        m_state = ns;
        if (bl != m_pressed) begin
            m_dbrun++;
            if (m_dbrun == DBNC_CYC) begin
                m_pressed = !m_pressed;
                m_dbrun = 0;
            end
        end else m_dbrun = 0;
        lh.push_back(pll_locked);
        bh.push_back(btn_rst_n);
        if (lh.size() > 2) void'(lh.pop_front());
        if (bh.size() > 2) void'(bh.pop_front());
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("cause", rst_cause, m_cause);
        chk("llc", llc, m_llc);
        chk("periph", periph_rst_n, (m_state == 3 || m_state == 4) ? 1 : 0);
        chk("core", core_rst_n, (m_state == 4) ? 1 : 0);
    endtask

    task automatic cycle(input bit lk, input bit bt, input bit sw);
        pll_locked = lk; btn_rst_n = bt; sw_rst_req = sw;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        sw_rst_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; pll_locked = 1'b0; btn_rst_n = 1'b1; sw_rst_req = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int t_p, t_c, hold_n, lk_left, bt_left;
        bit lk, bt, sw;

        // power-up sequence
        apply_reset();
        t_p = -1; t_c = -1; hold_n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (state == 3'd2) hold_n++;
            if (t_p < 0 && periph_rst_n) t_p = i;
            if (t_c < 0 && core_rst_n) t_c = i;
        end
        chk("hold_len", hold_n, HOLD_CYC);
        chk("core_lag", t_c - t_p, STAGE_GAP);
        chk("run_reached", state, 4);

        // lock loss in RUN for two cycles, then re-lock
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("loss_state", state, 1);
        chk("loss_cause", rst_cause, 1);
        chk("loss_cnt", llc, 1);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b0);

        // short button bounce, then a real press held past HOLD
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("bounce_run", state, 4);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("btn_hold", state, 2);
        chk("btn_cause", rst_cause, 2);
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b0);

        // software request in RUN, again in HOLD, then together with lock loss
        cycle(1'b1, 1'b1, 1'b1);
        chk("sw_state", state, 2);
        chk("sw_cause", rst_cause, 3);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("sw_lock_cause", rst_cause, 1);

        // lock glitch after three high samples in WAIT_LOCK
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("glitch_wait", state, 1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("glitch_hold", state, 2);

        // lock-loss counter saturation
        apply_reset();
        for (int n = 0; n < 260; n++) begin
            for (int k = 0; k < 40 && m_state != 2; k++) cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b1, 1'b1, 1'b0);
        end
        chk("llc_sat", llc, 255);

        // asynchronous reset during REL_PERIPH
        for (int k = 0; k < 60 && state != 3'd3; k++) cycle(1'b1, 1'b1, 1'b0);
        chk("reach_rel", state, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_periph", periph_rst_n, 0);
        chk("arst_core", core_rst_n, 0);
        chk("arst_cause", rst_cause, 0);
        chk("arst_llc", llc, 0);
        apply_reset();

        // randomized traffic
        lk_left = 0; bt_left = 0;
        for (int i = 0; i < 5000; i++) begin
            lk = 1'b1;
            if (lk_left > 0) begin
                lk = 1'b0; lk_left--;
            end else if ($urandom_range(0, 199) == 0) begin
                lk = 1'b0; lk_left = $urandom_range(0, 3);
            end
            bt = 1'b1;
            if (bt_left > 0) begin
                bt = 1'b0; bt_left--;
            end else if ($urandom_range(0, 79) == 0) begin
                bt = 1'b0; bt_left = $urandom_range(0, 14);
            end
            sw = ($urandom_range(0, 24) == 0);
            cycle(lk, bt, sw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
